// File: rtl/instr_issue_unit.sv
// instr_issue_unit: PC sequencer that fetches from a synchronous ROM and issues opcode/fields,
// holding LOAD/STORE for MEM_CYCLES extra cycles and honouring datapath stall in ISSUE only.
module instr_issue_unit #(
  parameter int PC_WIDTH   = 4,
  parameter int PROG_LEN   = 16,
  parameter int MEM_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stall,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [7:0]          imem_rdata,
  output logic [1:0]          opcode,
  output logic [1:0]          rd,
  output logic [1:0]          rs1,
  output logic [1:0]          rs2,
  output logic                issue_valid,
  output logic                mem_busy,
  output logic [PC_WIDTH-1:0] pc,
  output logic                done
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, MEM, HALT} state_t;
  state_t              r_state, w_state;
  logic [PC_WIDTH-1:0] r_pc, w_pc, r_addr, w_addr;
  logic [7:0]          r_ir, w_ir;
  logic [2:0]          r_cnt, w_cnt;
  logic                r_iv, w_iv, r_mb, w_mb, r_done, w_done, w_retire, w_last;
  assign w_last      = r_pc == PC_WIDTH'(PROG_LEN - 1);
  assign imem_addr   = r_addr;
  assign pc          = r_pc;
  assign opcode      = r_ir[7:6];
  assign rd          = r_ir[5:4];
  assign rs1         = r_ir[3:2];
  assign rs2         = r_ir[1:0];
  assign issue_valid = r_iv;
  assign mem_busy    = r_mb;
  assign done        = r_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_addr  <= '0;
      r_ir    <= 8'h00;
      r_cnt   <= 3'd0;
      r_iv    <= 1'b0;
      r_mb    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_addr  <= w_addr;
      r_ir    <= w_ir;
      r_cnt   <= w_cnt;
      r_iv    <= w_iv;
      r_mb    <= w_mb;
      r_done  <= w_done;
    end
  end
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_addr   = r_addr;
    w_ir     = r_ir;
    w_cnt    = r_cnt;
    w_iv     = r_iv;
    w_mb     = r_mb;
    w_done   = r_done;
    w_retire = 1'b0;
    case (r_state)
      IDLE:   w_state = start ? FETCH : IDLE;
      FETCH: begin
        w_addr  = r_pc;
        w_state = DECODE;
      end
      DECODE: begin
        w_ir    = imem_rdata;
        w_iv    = 1'b1;
        w_state = ISSUE;
      end
      ISSUE: if (!stall) begin
        if (r_ir[7]) begin
          w_state = MEM;
          w_iv    = 1'b0;
          w_mb    = 1'b1;
          w_cnt   = 3'(MEM_CYCLES - 1);
        end else w_retire = 1'b1;
      end
      MEM: if (r_cnt == 3'd0) w_retire = 1'b1; else w_cnt = r_cnt - 3'd1;
      HALT: if (!start) begin
        w_state = IDLE;
        w_pc    = '0;
        w_addr  = '0;
        w_done  = 1'b0;
      end
      default: w_state = IDLE;
    endcase
    // Shared retire path for ALU ops leaving ISSUE and memory ops leaving MEM
    if (w_retire) begin
      w_iv    = 1'b0;
      w_mb    = 1'b0;
      w_state = w_last ? HALT : FETCH;
      w_done  = w_last;
      w_pc    = w_last ? r_pc : r_pc + PC_WIDTH'(1);
      w_addr  = w_pc;
    end
  end
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: randomized program/stall/start stimulus checked against a per-instruction timeline model.
module tb_instr_issue_unit;
  localparam int PW = 4, PL = 6, MC = 3;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
  logic [PW-1:0] imem_addr, pc;
  logic [7:0]    imem_rdata;
  logic [1:0]    opcode, rd, rs1, rs2;
  logic          issue_valid, mem_busy, done;
  logic [7:0]    rom [16];
  logic [7:0]    m_ir;
  logic [18:0]   obs;
  int            n_chk = 0, n_pass = 0;
  instr_issue_unit #(.PC_WIDTH(PW), .PROG_LEN(PL), .MEM_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .issue_valid(issue_valid), .mem_busy(mem_busy), .pc(pc), .done(done)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) imem_rdata <= rom[imem_addr];
  assign obs = {done, issue_valid, mem_busy, pc, imem_addr, opcode, rd, rs1, rs2};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic expect_out(input string tag, input logic d, input logic iv, input logic mb,
                            input logic [PW-1:0] p, input logic [PW-1:0] a);
    chk(tag, 32'(obs), 32'({d, iv, mb, p, a, m_ir}));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input bit stalls, input int rst_at, output bit aborted);
    int s;
    aborted = 1'b0;
    start = 1'b1;
    stall = 1'($urandom);
    expect_out("idle", 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    for (int k = 0; k < PL; k++) begin
      for (int ph = 0; ph < 2; ph++) begin
        start = 1'($urandom);
        stall = 1'($urandom);
        expect_out($sformatf("fetch_decode%0d_%0d", k, ph), 1'b0, 1'b0, 1'b0, PW'(k), PW'(k));
        tick();
      end
      m_ir = rom[k];
      s = stalls ? int'($urandom_range(0, 4)) : 0;
      for (int j = 0; j <= s; j++) begin
        start = 1'($urandom);
        stall = (j < s);
        expect_out($sformatf("issue%0d_%0d", k, j), 1'b0, 1'b1, 1'b0, PW'(k), PW'(k));
        tick();
      end
      if (m_ir[7]) for (int j = 0; j < MC; j++) begin
        start = 1'($urandom);
        stall = 1'($urandom);
        expect_out($sformatf("mem%0d_%0d", k, j), 1'b0, 1'b0, 1'b1, PW'(k), PW'(k));
        if (k == rst_at && j == 1) begin
          #2 rst_n = 1'b0;
          #1;
          m_ir = 8'h00;
          expect_out("async_rst", 1'b0, 1'b0, 1'b0, '0, '0);
          start = 1'b1;
          tick();
          expect_out("rst_hold", 1'b0, 1'b0, 1'b0, '0, '0);
          @(negedge clk);
          rst_n = 1'b1;
          start = 1'b0;
          tick();
          expect_out("rst_idle", 1'b0, 1'b0, 1'b0, '0, '0);
          aborted = 1'b1;
          return;
        end
        tick();
      end
    end
  endtask
  task automatic halt_exit();
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stall = 1'($urandom);
      expect_out("halt", 1'b1, 1'b0, 1'b0, PW'(PL - 1), PW'(PL - 1));
      tick();
    end
    start = 1'b0;
    expect_out("halt_exit", 1'b1, 1'b0, 1'b0, PW'(PL - 1), PW'(PL - 1));
    tick();
  endtask
  initial begin
    bit ab;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h1B; rom[1] = 8'h46; rom[2] = 8'h9C;
    rom[3] = 8'hC5; rom[4] = 8'h2D; rom[5] = 8'hB1;
    m_ir = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_out("idle_hold", 1'b0, 1'b0, 1'b0, '0, '0);
    run(1'b0, -1, ab);
    halt_exit();
    run(1'b0, -1, ab);
    halt_exit();
    run(1'b1, -1, ab);
    halt_exit();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < PL; i++) rom[i] = 8'($urandom);
      if (r % 3 == 0) rom[r % PL][7] = 1'b1;
      run(1'b1, (r % 3 == 0) ? r % PL : -1, ab);
      if (!ab) halt_exit();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
